// File: rtl/thumb_issue_aligner_pkg.sv
// -----------------------------------------------------------------------------
// thumb_pkg
//   Shared definitions for the Thumb issue aligner: halfword width, the
//   Thumb-2 32-bit prefix encodings, the prefix test and the aligner
//   state type.
// -----------------------------------------------------------------------------
package thumb_pkg;

  localparam int HW_W = 16;

  // hw[15:11] values that mark the first halfword of a 32-bit instruction
  localparam logic [4:0] PFX_A = 5'b11101;
  localparam logic [4:0] PFX_B = 5'b11110;
  localparam logic [4:0] PFX_C = 5'b11111;

  // RUN  : both halfwords of each accepted fetch word are buffered
  // SKIP : next accepted word contributes only its upper halfword
  typedef enum logic {
    RUN  = 1'b0,
    SKIP = 1'b1
  } state_e;

  function automatic logic is_t32_prefix(input logic [HW_W-1:0] hw);
    return (hw[15:11] == PFX_A) || (hw[15:11] == PFX_B) || (hw[15:11] == PFX_C);
  endfunction

endpackage

// File: rtl/thumb_issue_aligner_if.sv
// -----------------------------------------------------------------------------
// thumb_issue_aligner_if
//   Fetch-side and decode-side handshake bundle of the aligner.
//   master : fetch/redirect source and instruction consumer (environment)
//   slave  : the aligner itself
//   flush/flush_pc       redirect request and target
//   fetch_valid/ready    32-bit fetch word handshake, fetch_data[15:0] older
//   dec_valid/ready      one instruction per handshake
//   dec_inst/_16/_pc     instruction in decoder format, size flag, address
// -----------------------------------------------------------------------------
interface thumb_issue_aligner_if;

  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic        dec_inst_16;
  logic [31:0] dec_pc;

  modport master (
    output flush, flush_pc, fetch_valid, fetch_data, dec_ready,
    input  fetch_ready, dec_valid, dec_inst, dec_inst_16, dec_pc
  );

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_data, dec_ready,
    output fetch_ready, dec_valid, dec_inst, dec_inst_16, dec_pc
  );

endinterface

// File: rtl/thumb_issue_aligner_hw_buf.sv
// -----------------------------------------------------------------------------
// thumb_hw_buf
//   Circular halfword FIFO. Up to two halfwords pushed and up to two popped
//   per cycle; exposes the two oldest entries and the occupancy.
//   clk, rst_n            clock, asynchronous active-low reset
//   i_clr                 synchronous clear (drops all entries)
//   i_push_n, i_push_hw0/1 number of halfwords to append (0..2), oldest first
//   i_pop_n               number of halfwords to remove (0..2)
//   o_head, o_head1       oldest and second-oldest halfword
//   o_count               occupancy
// The caller guarantees push never overflows and pop never exceeds count.
// -----------------------------------------------------------------------------
module thumb_hw_buf
  import thumb_pkg::*;
#(
  parameter int DEPTH_HW = 4,
  localparam int PW = $clog2(DEPTH_HW),
  localparam int CW = $clog2(DEPTH_HW + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic [1:0]      i_push_n,
  input  logic [HW_W-1:0] i_push_hw0,
  input  logic [HW_W-1:0] i_push_hw1,
  input  logic [1:0]      i_pop_n,
  output logic [HW_W-1:0] o_head,
  output logic [HW_W-1:0] o_head1,
  output logic [CW-1:0]   o_count
);

  logic [HW_W-1:0] r_slot [DEPTH_HW];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_rd1;
  logic [PW-1:0]   w_wr1;

  // Modular advance; DEPTH_HW need not be a power of two (e.g. 6)
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW:0] s;
    s = {1'b0, p} + {{(PW-1){1'b0}}, n};
    if (s >= (PW+1)'(DEPTH_HW)) s = s - (PW+1)'(DEPTH_HW);
    return s[PW-1:0];
  endfunction

  assign w_rd1   = ptr_add(r_rd, 2'd1);
  assign w_wr1   = ptr_add(r_wr, 2'd1);
  assign o_head  = r_slot[r_rd];
  assign o_head1 = r_slot[w_rd1];
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH_HW; i++) r_slot[i] <= '0;
    end else if (i_clr) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push_n != 2'd0) r_slot[r_wr]  <= i_push_hw0;
      if (i_push_n == 2'd2) r_slot[w_wr1] <= i_push_hw1;
      r_wr    <= ptr_add(r_wr, i_push_n);
      r_rd    <= ptr_add(r_rd, i_pop_n);
      r_count <= r_count - CW'(i_pop_n) + CW'(i_push_n);
    end
  end

endmodule

// File: rtl/thumb_issue_aligner.sv
// -----------------------------------------------------------------------------
// thumb_issue_aligner
//   Splits 32-bit fetch words into halfwords, assembles 16/32-bit Thumb
//   instructions and presents one per handshake to the decoder with its PC.
//   Branch redirects clear the buffer; a halfword-misaligned target drops the
//   lower halfword of the next fetched word.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    thumb_issue_aligner_if.slave (fetch, redirect and decode handshakes)
// -----------------------------------------------------------------------------
module thumb_issue_aligner
  import thumb_pkg::*;
#(
  parameter int          DEPTH_HW = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int CW = $clog2(DEPTH_HW + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  thumb_issue_aligner_if.slave   bus
);

  localparam logic [CW-1:0] C_PUSH_LIM = CW'(DEPTH_HW - 2);

  state_e          r_state;
  logic [31:0]     r_pc;
  logic [HW_W-1:0] w_head;
  logic [HW_W-1:0] w_head1;
  logic [CW-1:0]   w_count;
  logic            w_pfx;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [1:0]      w_pop_n;
  logic [1:0]      w_push_n;
  logic [HW_W-1:0] w_push_hw0;

  thumb_hw_buf #(.DEPTH_HW(DEPTH_HW)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (bus.flush),
    .i_push_n   (w_push_n),
    .i_push_hw0 (w_push_hw0),
    .i_push_hw1 (bus.fetch_data[31:16]),
    .i_pop_n    (w_pop_n),
    .o_head     (w_head),
    .o_head1    (w_head1),
    .o_count    (w_count)
  );

  assign w_pfx = is_t32_prefix(w_head);

  // A lone prefix must wait for its second halfword
  assign w_valid = !bus.flush &&
                   ((w_count >= CW'(1) && !w_pfx) || (w_count >= CW'(2) && w_pfx));
  assign w_pop   = w_valid && bus.dec_ready;
  assign w_pop_n = w_pop ? (w_pfx ? 2'd2 : 2'd1) : 2'd0;

  // Acceptance uses the current count only, so it never depends on dec_ready
  assign bus.fetch_ready = !bus.flush && (w_count <= C_PUSH_LIM);
  assign w_push          = bus.fetch_valid && bus.fetch_ready;
  assign w_push_n        = w_push ? ((r_state == SKIP) ? 2'd1 : 2'd2) : 2'd0;
  assign w_push_hw0      = (r_state == SKIP) ? bus.fetch_data[31:16] : bus.fetch_data[15:0];

  assign bus.dec_valid   = w_valid;
  assign bus.dec_inst    = w_pfx ? {w_head, w_head1} : {w_head, 16'h0000};
  assign bus.dec_inst_16 = !w_pfx;
  assign bus.dec_pc      = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else if (bus.flush) begin
      r_state <= bus.flush_pc[1] ? SKIP : RUN;
      r_pc    <= bus.flush_pc & 32'hFFFF_FFFE;
    end else begin
      if (w_push) r_state <= RUN;
      if (w_pop)  r_pc    <= r_pc + (w_pfx ? 32'd4 : 32'd2);
    end
  end

endmodule

// File: tb/tb_thumb_issue_aligner.sv
module tb_thumb_issue_aligner;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  thumb_issue_aligner_if bus();

  thumb_issue_aligner #(.DEPTH_HW(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    bus.flush        = 1'b0;
    bus.flush_pc     = 32'h0;
    bus.fetch_valid  = 1'b0;
    bus.fetch_data   = 32'h0;
    bus.dec_ready    = 1'b0;

    // Reset
    tick(); tick();
    rst_n = 1'b1;
    settle();
    chk("rst_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("rst_fready", {31'b0, bus.fetch_ready}, 32'd1);
    chk("rst_pc", bus.dec_pc, 32'h0);
    chk("rst_inst", bus.dec_inst, 32'h0);
    chk("rst_inst16", {31'b0, bus.dec_inst_16}, 32'd1);

    // Two 16-bit instructions in one word
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h4608_2001; bus.dec_ready = 1'b1;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("t2_valid0", {31'b0, bus.dec_valid}, 32'd1);
    chk("t2_inst0", bus.dec_inst, 32'h2001_0000);
    chk("t2_16_0", {31'b0, bus.dec_inst_16}, 32'd1);
    chk("t2_pc0", bus.dec_pc, 32'h0);
    tick();
    chk("t2_inst1", bus.dec_inst, 32'h4608_0000);
    chk("t2_pc1", bus.dec_pc, 32'h2);
    tick();
    chk("t2_empty", {31'b0, bus.dec_valid}, 32'd0);
    chk("t2_pc2", bus.dec_pc, 32'h4);

    // Redirect to 0 (aligned), then a 32-bit instruction straddling two words
    bus.flush = 1'b1; bus.flush_pc = 32'h0; bus.dec_ready = 1'b0;
    settle();
    chk("fl0_fready", {31'b0, bus.fetch_ready}, 32'd0);
    tick();
    bus.flush = 1'b0;
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hF000_2001;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("t3_inst0", bus.dec_inst, 32'h2001_0000);
    chk("t3_pc0", bus.dec_pc, 32'h0);
    bus.dec_ready = 1'b1;
    tick();
    chk("t3_lone_pfx", {31'b0, bus.dec_valid}, 32'd0);
    chk("t3_pc1", bus.dec_pc, 32'h2);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2000_F800;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("t3_valid32", {31'b0, bus.dec_valid}, 32'd1);
    chk("t3_inst32", bus.dec_inst, 32'hF000_F800);
    chk("t3_16_32", {31'b0, bus.dec_inst_16}, 32'd0);
    chk("t3_pc32", bus.dec_pc, 32'h2);
    tick();
    chk("t3_inst2", bus.dec_inst, 32'h2000_0000);
    chk("t3_pc2", bus.dec_pc, 32'h6);
    tick();
    chk("t3_empty", {31'b0, bus.dec_valid}, 32'd0);
    chk("t3_pc3", bus.dec_pc, 32'h8);

    // Backpressure until full
    bus.dec_ready = 1'b0;
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2102_2101;
    tick();
    settle();
    chk("t4_fready_c2", {31'b0, bus.fetch_ready}, 32'd1);
    bus.fetch_data = 32'h2104_2103;
    tick();
    chk("t4_fready_c4", {31'b0, bus.fetch_ready}, 32'd0);
    bus.fetch_data = 32'h2106_2105;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("t4_held_inst", bus.dec_inst, 32'h2101_0000);
    chk("t4_held_pc", bus.dec_pc, 32'h8);
    chk("t4_fready_full", {31'b0, bus.fetch_ready}, 32'd0);
    bus.dec_ready = 1'b1;
    tick();
    chk("t4_inst1", bus.dec_inst, 32'h2102_0000);
    chk("t4_pc1", bus.dec_pc, 32'hA);
    chk("t4_fready_c3", {31'b0, bus.fetch_ready}, 32'd0);
    tick();
    chk("t4_inst2", bus.dec_inst, 32'h2103_0000);
    chk("t4_pc2", bus.dec_pc, 32'hC);
    chk("t4_fready_back", {31'b0, bus.fetch_ready}, 32'd1);
    tick();
    chk("t4_inst3", bus.dec_inst, 32'h2104_0000);
    chk("t4_pc3", bus.dec_pc, 32'hE);
    tick();
    chk("t4_no_extra", {31'b0, bus.dec_valid}, 32'd0);
    chk("t4_pc4", bus.dec_pc, 32'h10);

    // Misaligned redirect: lower halfword of next word dropped
    bus.flush = 1'b1; bus.flush_pc = 32'h0000_0103;
    tick();
    bus.flush = 1'b0;
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hBF00_1234;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("t5_inst", bus.dec_inst, 32'hBF00_0000);
    chk("t5_pc", bus.dec_pc, 32'h102);
    chk("t5_16", {31'b0, bus.dec_inst_16}, 32'd1);
    tick();
    chk("t5_single", {31'b0, bus.dec_valid}, 32'd0);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2202_2201;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("t5_run_inst0", bus.dec_inst, 32'h2201_0000);
    chk("t5_run_pc0", bus.dec_pc, 32'h104);
    tick();
    chk("t5_run_inst1", bus.dec_inst, 32'h2202_0000);
    chk("t5_run_pc1", bus.dec_pc, 32'h106);
    tick();

    // Flush while a prefix waits and a word is offered
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'hF7FF_2301;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("t6_inst0", bus.dec_inst, 32'h2301_0000);
    chk("t6_pc0", bus.dec_pc, 32'h108);
    tick();
    chk("t6_pending", {31'b0, bus.dec_valid}, 32'd0);
    bus.flush = 1'b1; bus.flush_pc = 32'h0000_0200;
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2401_F800;
    settle();
    chk("t6_fready", {31'b0, bus.fetch_ready}, 32'd0);
    chk("t6_valid_fl", {31'b0, bus.dec_valid}, 32'd0);
    tick();
    bus.flush = 1'b0; bus.fetch_valid = 1'b0;
    settle();
    chk("t6_after_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("t6_after_pc", bus.dec_pc, 32'h200);
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2502_2501;
    tick();
    bus.fetch_valid = 1'b0; bus.dec_ready = 1'b0;
    settle();
    chk("t6_new_inst", bus.dec_inst, 32'h2501_0000);
    chk("t6_new_pc", bus.dec_pc, 32'h200);

    // Asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    settle();
    chk("ar_valid", {31'b0, bus.dec_valid}, 32'd0);
    chk("ar_pc", bus.dec_pc, 32'h0);
    chk("ar_fready", {31'b0, bus.fetch_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    chk("ar_empty", {31'b0, bus.dec_valid}, 32'd0);

    // PC wrap from the top of the address space
    bus.flush = 1'b1; bus.flush_pc = 32'hFFFF_FFFE; bus.dec_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.fetch_valid = 1'b1; bus.fetch_data = 32'h2602_2601;
    tick();
    bus.fetch_valid = 1'b0;
    settle();
    chk("wr_inst", bus.dec_inst, 32'h2602_0000);
    chk("wr_pc", bus.dec_pc, 32'hFFFF_FFFE);
    tick();
    chk("wr_empty", {31'b0, bus.dec_valid}, 32'd0);
    chk("wr_pc_wrap", bus.dec_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thumb_issue_aligner.md
Name: thumb_issue_aligner

Overview:
- Sits between the instruction fetch port and the `decoder` block.
- Accepts 32-bit fetch words and splits them into halfwords.
- Recognises Thumb-2 32-bit prefixes and assembles 16/32-bit instructions.
- Presents one instruction per handshake to the decoder in its `inst` / `inst_16` format, with the instruction PC. Handles branch flushes, including halfword-misaligned targets.

Parameters:
- DEPTH_HW, 4, halfword buffer depth; legal values 4..8, even.
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  redirect; clears buffered halfwords.
- flush_pc  in  32  redirect target; bit0 ignored.
- fetch_valid  in  1  fetch word valid.
- fetch_ready  out  1  aligner can accept a word.
- fetch_data  in  32  [15:0] = older halfword, [31:16] = younger.
- dec_valid  out  1  instruction available.
- dec_ready  in  1  decoder consumes instruction.
- dec_inst  out  32  instruction, decoder format.
- dec_inst_16  out  1  1 = 16-bit instruction.
- dec_pc  out  32  address of dec_inst.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - buffer slots cleared to 0, count = 0, pc = RESET_PC, state = RUN.
  - dec_valid = 0, dec_inst = 0, dec_inst_16 = 1, dec_pc = RESET_PC, fetch_ready = 1.
  - Reset asserted mid-operation discards all buffered halfwords immediately.
- 32-bit prefix test: hw[15:11] ∈ {11101, 11110, 11111}. Any other value is a 16-bit instruction.
- Output format:
  - 16-bit: dec_inst = {hw, 16'h0000}, dec_inst_16 = 1.
  - 32-bit: dec_inst = {hw_first, hw_second}, dec_inst_16 = 0.
  - Opcode bits always appear in dec_inst[31:26].
- dec_valid:
  - = !flush && (count >= 1 && head is 16-bit, or count >= 2 && head is a prefix).
  - A prefix alone in the buffer never raises dec_valid.
  - dec_inst, dec_inst_16 and dec_pc come from registers. They are stable while dec_valid && !dec_ready.
- Pop: dec_valid && dec_ready. Removes 1 or 2 halfwords; pc += 2 or 4 (mod 2^32, wraps).
- Push:
  - fetch_ready = !flush && (count <= DEPTH_HW - 2), computed from the current count only (no pop lookahead).
  - A push on fetch_valid && fetch_ready appends 2 halfwords (RUN) or 1 halfword (SKIP).
- Latency: a word accepted at edge N produces dec_valid after edge N (visible in cycle N+1).
- Simultaneous push and pop in the same edge: count_next = count - popped + pushed. FIFO order is preserved.
- State machine:
  - RUN: both halfwords of each accepted word are pushed, in order [15:0] then [31:16].
  - SKIP: entered on flush with flush_pc[1] = 1. The next accepted word pushes only [31:16], then state returns to RUN.
- Flush (highest priority except reset):
  - In the flush cycle: count = 0, pc = {flush_pc[31:1], 1'b0}.
  - state = SKIP if flush_pc[1] = 1, else RUN.
  - fetch_data and dec_ready in that cycle are ignored (no push, no pop).
  - A half-assembled 32-bit instruction is discarded.
- Full: count = DEPTH_HW or DEPTH_HW - 1 → fetch_ready = 0. Empty: count = 0 → dec_valid = 0.

Decomposition:
- Package thumb_pkg:
  - HW_W = 16.
  - prefix constants 5'b11101, 5'b11110, 5'b11111.
  - function is_t32_prefix(hw).
  - state enum {RUN, SKIP}.
- Sub-module thumb_hw_buf: circular halfword FIFO.
  - push of 0/1/2 and pop of 0/1/2 per cycle.
  - outputs head and head+1 halfwords plus count.
  - synchronous clear; asynchronous reset on rst_n.
- Top level holds the FSM, pc register, prefix detection and output formatting.

Test Plan:
1. Hold rst_n = 0, then release → dec_valid = 0, fetch_ready = 1, dec_pc = 0, dec_inst = 0; pulsing rst_n low mid-stream empties the buffer within the same cycle.
2. Push 0x4608_2001 with dec_ready = 1:
   - then dec_inst = 0x2001_0000, inst_16 = 1, pc = 0;
   - next cycle 0x4608_0000, pc = 2; then dec_valid = 0.
3. Straddling 32-bit instruction: push 0xF000_2001, then 0x2000_F800.
   - 0x2001 is issued at pc 0.
   - dec_valid stays 0 while only 0xF000 is buffered.
   - Then dec_inst = 0xF000_F800, inst_16 = 0, pc = 2.
   - Then 0x2000_0000 at pc = 6.
4. Backpressure: dec_ready = 0, push 16-bit words until count = 4 → fetch_ready = 0 and dec_inst held stable; release dec_ready → one pop per cycle and fetch_ready returns to 1 when count ≤ 2.
5. Flush with flush_pc = 0x0000_0103, then push 0xBF00_1234 → 0x1234 dropped, dec_inst = 0xBF00_0000, dec_pc = 0x102, inst_16 = 1.
6. Flush while prefix 0xF7FF is pending and a fetch word is offered in the same cycle → word not accepted, prefix discarded, dec_valid = 0, dec_pc = flush target.
